saturn_debug_uart_tx: RTL and testbench
=======================================

Name: saturn_debug_uart_tx

Overview:
- Downstream consumer of the bus controller's debug character stream (char_to_send / char_valid / char_send / serial_busy).
- Buffers characters in a small FIFO and serialises them as 8N1 UART frames on a single TX pin.
- Drives the busy flag back to the controller so it stalls when the buffer is full.
- Sits at top level beside saturn_bus; its output goes straight to the FPGA serial pin.

Parameters:
- CLKS_PER_BIT, 104, i_clk cycles per UART bit (at least 2).
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_char_to_send  input  8  character from bus controller.
- i_char_valid  input  1  i_char_to_send holds a valid character.
- i_char_send  input  1  request to enqueue the character this cycle.
- o_serial_busy  output  1  FIFO full; the controller must not send.
- o_tx  output  1  UART line; idles high.
- o_fifo_level  output  FIFO_AW+1  number of queued characters.
- o_overrun  output  1  sticky: a character was offered while full.

Behaviour:
- Reset (sync, i_reset high at an edge): FIFO empty, o_fifo_level=0, o_serial_busy=0, o_overrun=0, o_tx=1, FSM=IDLE, bit and baud counters=0. A frame in progress is aborted immediately; o_tx returns high on that edge.
- Accept: on an edge with i_char_send && i_char_valid && !o_serial_busy, write i_char_to_send at the write pointer and increment the pointer.
  - i_char_send without i_char_valid is ignored.
- o_serial_busy is combinational: (o_fifo_level == 2**FIFO_AW). It is evaluated from the pre-edge level, so a push while full is rejected even if a pop happens on the same edge.
- Push while full (send && valid && busy): character dropped, o_overrun set to 1. It stays set until reset.
- Pointers are FIFO_AW bits and wrap modulo depth. Level range is 0..2**FIFO_AW.
  - Simultaneous push and pop leaves the level unchanged.
  - A push into an empty FIFO is not bypassed; it must be written first.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If level>0 at an edge, pop the head into shift register sr[7:0], clear the baud counter, go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=sr[0], LSB first. Hold each bit for CLKS_PER_BIT cycles, then shift sr right. After bit 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. At the end, if level>0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Timing:
  - A character pushed at edge E into an empty FIFO with FSM idle is popped at edge E+1. o_tx is low from edge E+2.
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have no gap between the stop bit and the next start bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. Width is clog2(CLKS_PER_BIT) bits.
- o_tx is registered (glitch-free).

Optional Feature:
- Macro: SATURN_UART_CRLF_EN.
- Defined: when the byte popped is 0x0A, the block first transmits a 0x0D frame, then a 0x0A frame.
  - The 0x0A is held in a one-entry pending register, so it consumes one FIFO slot only.
  - After the 0x0D STOP, the FSM goes to START with the pending byte before checking the FIFO.
  - Reset clears the pending register.
- Undefined: bytes are transmitted verbatim and no pending register exists.

Test Plan:
- Reset then idle 50 cycles -> o_tx=1, o_serial_busy=0, o_fifo_level=0, o_overrun=0.
- CLKS_PER_BIT=4, push 0x41 at edge E -> o_tx low at E+2. Sampled bits 1,0,0,0,0,0,1,0, then stop=1. Frame is 40 cycles; o_fifo_level returns to 0 at E+1.
- FIFO_AW=2, push 5 chars on consecutive cycles while the FSM is blocked by an in-progress frame -> o_serial_busy=1 at level 4, 5th char dropped, o_overrun=1. Received sequence is the first 4 chars plus the char in flight.
- Push 0x31 and 0x32 back-to-back -> second start bit begins on the cycle immediately after the first stop bit ends (frame spacing exactly 10*CLKS_PER_BIT).
- Assert i_reset mid-DATA with 3 queued chars -> next edge: o_tx=1, level=0, FSM IDLE. No further frames appear.
- With SATURN_UART_CRLF_EN, push 0x0A -> frames 0x0D then 0x0A are received, o_fifo_level peaks at 1. Without the macro, only 0x0A is received.

Source files
------------

// File: rtl/saturn_debug_uart_tx.sv
// saturn_debug_uart_tx: FIFO-buffered 8N1 UART transmitter for the bus controller's debug character stream; optional SATURN_UART_CRLF_EN expands LF to CR LF.
module saturn_debug_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_char_to_send,
  input  logic             i_char_valid,
  input  logic             i_char_send,
  output logic             o_serial_busy,
  output logic             o_tx,
  output logic [FIFO_AW:0] o_fifo_level,
  output logic             o_overrun
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] sr, head, load;
  logic push, pop, baud_end, pend;
  assign o_serial_busy = o_fifo_level == FULL;
  assign push = i_char_send && i_char_valid && !o_serial_busy;
  assign baud_end = baud == BAUD_MAX;
  assign head = mem[rptr];
`ifdef SATURN_UART_CRLF_EN
  logic pend_q;
  assign pend = pend_q;
  assign load = head == 8'h0A ? 8'h0D : head;
  // LF waits here while its CR goes out, so it only ever occupies one FIFO slot
  always_ff @(posedge i_clk) begin
    if (i_reset) pend_q <= 1'b0;
    else pend_q <= pop ? head == 8'h0A : (state == STOP && baud_end) ? 1'b0 : pend_q;
  end
`else
  assign pend = 1'b0;
  assign load = head;
`endif
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = o_fifo_level != '0;
        state_n = pop ? START : IDLE;
      end
      START: state_n = baud_end ? DATA : START;
      DATA: state_n = (baud_end && bit_idx == 3'd7) ? STOP : DATA;
      STOP: begin
        pop = baud_end && !pend && o_fifo_level != '0;
        state_n = !baud_end ? STOP : (pend || pop) ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem[wptr] <= i_char_to_send;
  end
  // o_tx follows the state one cycle late so the line is driven straight from a flop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      o_fifo_level <= '0;
      o_overrun <= 1'b0;
      o_tx <= 1'b1;
      baud <= '0;
      bit_idx <= '0;
      sr <= '0;
    end else begin
      state <= state_n;
      wptr <= wptr + FIFO_AW'(push);
      rptr <= rptr + FIFO_AW'(pop);
      o_fifo_level <= o_fifo_level + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
      o_overrun <= o_overrun | (i_char_send && i_char_valid && o_serial_busy);
      o_tx <= state == START ? 1'b0 : state == DATA ? sr[0] : 1'b1;
      baud <= (state == IDLE || baud_end) ? '0 : baud + BW'(1);
      bit_idx <= state != DATA ? 3'd0 : baud_end ? bit_idx + 3'd1 : bit_idx;
      sr <= pop ? load : (pend && state == STOP && baud_end) ? 8'h0A : (state == DATA && baud_end) ? sr >> 1 : sr;
    end
  end
endmodule

// File: tb/tb_saturn_debug_uart_tx.sv
// tb_saturn_debug_uart_tx: directed checks of buffering, framing, back-pressure and reset abort at 4 clocks per bit and a 4-deep FIFO.
module tb_saturn_debug_uart_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] ch = '0;
  logic valid = 1'b0, send = 1'b0;
  logic busy, tx, overrun;
  logic [2:0] level;
  int cyc = 0, n_cmp = 0, n_err = 0;
  logic tx_log [4096];

  saturn_debug_uart_tx #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_char_to_send(ch), .i_char_valid(valid),
    .i_char_send(send), .o_serial_busy(busy), .o_tx(tx), .o_fifo_level(level),
    .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 4096) tx_log[cyc] = tx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] c, output int e);
    ch = c; valid = 1'b1; send = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    send = 1'b0; valid = 1'b0;
  endtask

  // st is the first cycle the start bit is on the line; sample the middle of each bit
  task automatic check_frame(input string tag, input int st, input logic [7:0] c);
    logic [9:0] fr;
    fr = {1'b1, c, 1'b0};
    for (int k = 0; k < 10; k++) chk($sformatf("%s_bit%0d", tag, k), 32'(tx_log[st + 2 + 4 * k]), 32'(fr[k]));
  endtask

  initial begin
    int e, e2, r, lows;
    tick(2);
    rst = 1'b0;
    tick(50);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_level", 32'(level), 0);
    chk("reset_overrun", 32'(overrun), 0);

    ch = 8'h55; send = 1'b1; valid = 1'b0;
    tick(1);
    send = 1'b0;
    chk("send_without_valid", 32'(level), 0);

    push(8'h41, e);
    chk("single_level_after_push", 32'(level), 1);
    tick(1);
    chk("single_level_after_pop", 32'(level), 0);
    chk("single_tx_still_idle", 32'(tx), 1);
    tick(1);
    chk("single_tx_low_E2", 32'(tx), 0);
    tick(45);
    check_frame("single", e + 2, 8'h41);
    chk("single_pre_start", 32'(tx_log[e + 1]), 1);
    chk("single_start_last", 32'(tx_log[e + 5]), 0);
    chk("single_bit0_first", 32'(tx_log[e + 6]), 1);
    chk("single_stop_last", 32'(tx_log[e + 41]), 1);
    chk("single_idle_after", 32'(tx_log[e + 42]), 1);

    push(8'h31, e);
    push(8'h32, e2);
    chk("b2b_push_spacing", 32'(e2 - e), 1);
    tick(90);
    check_frame("b2b_first", e + 2, 8'h31);
    check_frame("b2b_second", e + 42, 8'h32);
    chk("b2b_stop_end", 32'(tx_log[e + 41]), 1);
    chk("b2b_start_begin", 32'(tx_log[e + 42]), 0);
    chk("b2b_prev_start_len", 32'(tx_log[e + 45]), 0);

    chk("full_overrun_clear", 32'(overrun), 0);
    push(8'h10, e);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      push(8'h11 + 8'(i), e2);
      if (i == 3) begin
        chk("full_busy_at_4", 32'(busy), 1);
        chk("full_level_4", 32'(level), 4);
        chk("full_overrun_not_yet", 32'(overrun), 0);
      end
    end
    chk("full_level_after_drop", 32'(level), 4);
    chk("full_overrun_set", 32'(overrun), 1);
    tick(210);
    for (int i = 0; i < 5; i++) check_frame($sformatf("full_frame%0d", i), e + 2 + 40 * i, 8'h10 + 8'(i));
    chk("full_no_sixth_frame", 32'(tx_log[e + 204]), 1);
    chk("full_drained", 32'(level), 0);
    chk("full_overrun_sticky", 32'(overrun), 1);

    push(8'h00, e);
    tick(1);
    push(8'h51, e2);
    push(8'h52, e2);
    push(8'h53, e2);
    chk("abort_queued", 32'(level), 3);
    tick(6);
    chk("abort_tx_in_data", 32'(tx), 0);
    rst = 1'b1;
    r = cyc + 1;
    tick(1);
    chk("abort_tx_high", 32'(tx), 1);
    chk("abort_level", 32'(level), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_overrun", 32'(overrun), 0);
    rst = 1'b0;
    tick(100);
    lows = 0;
    for (int i = 0; i < 100; i++) lows += int'(!tx_log[r + i]);
    chk("abort_no_more_frames", 32'(lows), 0);

    push(8'h0A, e);
    chk("lf_level_peak", 32'(level), 1);
    tick(1);
    chk("lf_level_popped", 32'(level), 0);
    tick(90);
`ifdef SATURN_UART_CRLF_EN
    check_frame("lf_cr", e + 2, 8'h0D);
    check_frame("lf_lf", e + 42, 8'h0A);
`else
    check_frame("lf_verbatim", e + 2, 8'h0A);
    chk("lf_no_extra_frame", 32'(tx_log[e + 44]), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
